// File: rtl/lzs_pkg.sv
// rtl/lzs_pkg.sv - shared LZS word/code constants and encoder state type
//
// Purpose: constants common to encode_out and decode_in (word, code and
// width sizes), the bit-packer accumulator sizing, the packer state enum
// and a width-clipping helper.
// Ports: none (package).
package lzs_pkg;

  localparam int LZS_WORD_W  = 64;
  localparam int LZS_CODE_W  = 13;
  localparam int LZS_WIDTH_W = 4;
  // Up to 63 residual bits plus one 13-bit code, plus one bit of headroom.
  localparam int LZS_ACC_W   = LZS_WORD_W + LZS_CODE_W;
  localparam int LZS_CNT_W   = 7;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } lzs_enc_state_e;

  // Widths 14 and 15 are not legal codes; treat them as a full 13-bit code.
  function automatic logic [LZS_WIDTH_W-1:0] lzs_clip_width(
    input logic [LZS_WIDTH_W-1:0] w
  );
    return (w > LZS_WIDTH_W'(LZS_CODE_W)) ? LZS_WIDTH_W'(LZS_CODE_W) : w;
  endfunction

endpackage

// File: rtl/encode_align.sv
// rtl/encode_align.sv - places one code token at the accumulator fill point
//
// Purpose: combinational shifter. Masks the code to its width and moves its
// first-sent bit (bit width-1) to accumulator position ACC_W-1-cnt, so the
// result can simply be OR-ed into the accumulator.
// Ports:
//   i_code_data  - code bits, right-aligned
//   i_code_width - already-clipped width, 0..13
//   i_cnt        - bits currently held in the accumulator (< 64 when used)
//   o_aligned    - token positioned in accumulator coordinates
module encode_align
  import lzs_pkg::*;
(
  input  logic [LZS_CODE_W-1:0]  i_code_data,
  input  logic [LZS_WIDTH_W-1:0] i_code_width,
  input  logic [LZS_CNT_W-1:0]   i_cnt,
  output logic [LZS_ACC_W-1:0]   o_aligned
);

  logic [LZS_CODE_W-1:0] w_mask;
  logic [LZS_ACC_W-1:0]  w_token;

  // Shifting all-ones by 13 leaves zero, so width 13 yields a full mask.
  assign w_mask  = ~({LZS_CODE_W{1'b1}} << i_code_width);
  assign w_token = {i_code_data & w_mask, {LZS_WORD_W{1'b0}}};

  // Left-justify the token at the accumulator MSB, then slide it down past
  // the bits already held.
  assign o_aligned = (w_token << (LZS_WIDTH_W'(LZS_CODE_W) - i_code_width)) >> i_cnt;

endmodule

// File: rtl/encode_out.sv
// rtl/encode_out.sv - LZS encoder output bit-packer (codes to 64-bit words)
//
// Purpose: concatenates 0..13-bit code tokens MSB-first into a bitstream and
// writes 64-bit words to the destination FIFO with an active-low put strobe.
// A flush zero-pads the final partial word and pulses flush_done.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   ce                  - clock enable; freezes all state when low
//   code_data/width     - token bits (right-aligned) and bit count
//   code_valid/ready    - token handshake
//   flush, flush_done   - flush request level, completion pulse
//   dst_full            - destination FIFO full
//   m_dst_putn, fo      - active-low word strobe, output word
module encode_out
  import lzs_pkg::*;
#(
  parameter int WORD_W = LZS_WORD_W,
  parameter int CODE_W = LZS_CODE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [CODE_W-1:0]      code_data,
  input  logic [LZS_WIDTH_W-1:0] code_width,
  input  logic                   code_valid,
  output logic                   code_ready,
  input  logic                   flush,
  output logic                   flush_done,
  input  logic                   dst_full,
  output logic                   m_dst_putn,
  output logic [WORD_W-1:0]      fo
);

  localparam int                   ACC_W    = WORD_W + CODE_W;
  localparam logic [LZS_CNT_W-1:0] WORD_CNT = LZS_CNT_W'(WORD_W);

  lzs_enc_state_e         r_state;
  logic [ACC_W-1:0]       r_acc;
  logic [LZS_CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]      r_fo;
  logic                   r_putn;
  logic                   r_flush_done;

  logic [LZS_WIDTH_W-1:0] w_width;
  logic [ACC_W-1:0]       w_aligned;
  logic [WORD_W-1:0]      w_pad_mask;

  assign w_width = lzs_clip_width(code_width);

  encode_align u_align (
    .i_code_data  (code_data),
    .i_code_width (w_width),
    .i_cnt        (r_cnt),
    .o_aligned    (w_aligned)
  );

  // Keeps the top cnt bits of the final word (cnt is 1..64 where used).
  assign w_pad_mask = ~({WORD_W{1'b1}} >> r_cnt);

  // A full word pending blocks new tokens, so accept and emit never overlap.
  assign code_ready = ce && (r_state == RUN) && (r_cnt < WORD_CNT);

  assign fo         = r_fo;
  assign m_dst_putn = r_putn;
  assign flush_done = r_flush_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_fo         <= '0;
      r_putn       <= 1'b1;
      r_flush_done <= 1'b0;
    end else begin
      r_putn       <= 1'b1;
      r_flush_done <= 1'b0;
      if (ce) begin
        case (r_state)
          RUN: begin
            if (r_cnt >= WORD_CNT) begin
              if (!dst_full) begin
                r_fo   <= r_acc[ACC_W-1 -: WORD_W];
                r_putn <= 1'b0;
                r_acc  <= r_acc << WORD_W;
                r_cnt  <= r_cnt - WORD_CNT;
              end
            end else if (code_valid) begin
              r_acc <= r_acc | w_aligned;
              r_cnt <= r_cnt + LZS_CNT_W'(w_width);
            end
            // A token offered alongside flush wins; flush is taken once
            // code_valid drops.
            if (flush && !code_valid) begin
              r_state <= FLUSH;
            end
          end
          FLUSH: begin
            if (r_cnt > WORD_CNT) begin
              if (!dst_full) begin
                r_fo   <= r_acc[ACC_W-1 -: WORD_W];
                r_putn <= 1'b0;
                r_acc  <= r_acc << WORD_W;
                r_cnt  <= r_cnt - WORD_CNT;
              end
            end else if (r_cnt != '0) begin
              if (!dst_full) begin
                r_fo    <= r_acc[ACC_W-1 -: WORD_W] & w_pad_mask;
                r_putn  <= 1'b0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= DONE;
              end
            end else begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_flush_done <= 1'b1;
            r_state      <= RUN;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_encode_out.sv
// tb/tb_encode_out.sv - directed and stream-level bench for encode_out
module tb_encode_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [12:0] code_data;
  logic [3:0]  code_width;
  logic        code_valid;
  logic        code_ready;
  logic        flush;
  logic        flush_done;
  logic        dst_full;
  logic        m_dst_putn;
  logic [63:0] fo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_put = 0;
  int n_done = 0;
  int put_cyc = 0;
  int done_cyc = 0;
  logic [63:0] words[$];

  encode_out dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .code_data  (code_data),
    .code_width (code_width),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .dst_full   (dst_full),
    .m_dst_putn (m_dst_putn),
    .fo         (fo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!m_dst_putn) begin
      n_put   = n_put + 1;
      put_cyc = cyc;
      words.push_back(fo);
    end
    if (flush_done) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [12:0] d, input logic [3:0] w);
    int n = 0;
    code_data  = d;
    code_width = w;
    code_valid = 1'b1;
    while (!code_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("send_ready_timeout", 64'(code_ready), 64'd1);
    step();
    code_valid = 1'b0;
  endtask

  task automatic do_flush(input string tag);
    int n  = 0;
    int d0 = n_done;
    flush = 1'b1;
    while (n_done == d0 && n < 200) begin
      step();
      n++;
    end
    flush = 1'b0;
    chk(tag, 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    int p0, d0, rdy, acc_cyc, n, bits, bad, pad_bad, pos;
    logic [12:0] td[10000];
    logic [3:0]  tw[10000];
    logic [12:0] v;
    logic [63:0] last;

    rst = 1'b1; ce = 1'b1; code_valid = 1'b0; flush = 1'b0; dst_full = 1'b0;
    code_data = '0; code_width = '0;
    step(); step();
    chk("rst_fo", fo, 64'd0);
    chk("rst_putn", 64'(m_dst_putn), 64'd1);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_ready", 64'(code_ready), 64'd1);
    rst = 1'b0;
    step();

    // Five full-width all-ones codes: one word of ones, one bit left over.
    p0 = n_put;
    repeat (5) send(13'h1FFF, 4'd13);
    step(); step();
    chk("ones_puts", 64'(n_put - p0), 64'd1);
    chk("ones_word", fo, 64'hFFFF_FFFF_FFFF_FFFF);
    do_flush("ones_flush_done");
    chk("ones_puts_after_flush", 64'(n_put - p0), 64'd2);
    chk("ones_tail_word", words[$], 64'h8000_0000_0000_0000);

    // Bit ordering and flush_done one cycle after the strobe.
    p0 = n_put;
    send(13'h1A5, 4'd9);
    do_flush("order_flush_done");
    chk("order_puts", 64'(n_put - p0), 64'd1);
    chk("order_word", words[$], 64'hD280_0000_0000_0000);
    chk("order_done_lag", 64'(done_cyc - put_cyc), 64'd1);

    // Width 15 behaves as 13.
    send(13'h1FFF, 4'd15);
    do_flush("clip_flush_done");
    chk("clip_word", words[$], 64'hFFF8_0000_0000_0000);

    // Width-0 tokens add nothing; the following flush is empty.
    p0 = n_put; d0 = n_done;
    repeat (3) send(13'h1FFF, 4'd0);
    do_flush("empty_flush_done");
    repeat (3) step();
    chk("empty_puts", 64'(n_put - p0), 64'd0);
    chk("empty_single_pulse", 64'(n_done - d0), 64'd1);

    // Backpressure with exactly 64 bits buffered.
    dst_full = 1'b1;
    for (int i = 0; i < 16; i++) send(13'(i), 4'd4);
    p0 = n_put; rdy = 0;
    repeat (20) begin
      step();
      if (code_ready) rdy++;
    end
    chk("bp_ready_cycles", 64'(rdy), 64'd0);
    chk("bp_no_strobe", 64'(n_put - p0), 64'd0);
    dst_full = 1'b0;
    step();
    chk("bp_strobe", 64'(m_dst_putn), 64'd0);
    chk("bp_word", fo, 64'h0123_4567_89AB_CDEF);
    step();
    chk("bp_strobe_single", 64'(n_put - p0), 64'd1);

    // Clock enable low forces code_ready low.
    ce = 1'b0;
    step();
    chk("ce_ready", 64'(code_ready), 64'd0);
    ce = 1'b1;
    step();

    // Simultaneous code_valid and flush: code first, flush on the next edge.
    p0 = n_put; d0 = n_done;
    code_data = 13'h00F; code_width = 4'd4; code_valid = 1'b1; flush = 1'b1;
    step();
    acc_cyc = cyc;
    code_valid = 1'b0;
    n = 0;
    while (n_done == d0 && n < 50) begin
      step();
      n++;
    end
    flush = 1'b0;
    chk("sim_flush_done", 64'(n_done - d0), 64'd1);
    chk("sim_puts", 64'(n_put - p0), 64'd1);
    chk("sim_word", words[$], 64'hF000_0000_0000_0000);
    chk("sim_latency", 64'(put_cyc - acc_cyc), 64'd2);

    // Reset while a flush is stalled by dst_full.
    send(13'h1A5, 4'd9);
    dst_full = 1'b1;
    flush = 1'b1;
    repeat (3) step();
    p0 = n_put; d0 = n_done;
    #2 rst = 1'b1;
    #1;
    chk("midrst_fo", fo, 64'd0);
    chk("midrst_putn", 64'(m_dst_putn), 64'd1);
    chk("midrst_flush_done", 64'(flush_done), 64'd0);
    flush = 1'b0;
    dst_full = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("midrst_no_strobe", 64'(n_put - p0), 64'd0);
    chk("midrst_no_done", 64'(n_done - d0), 64'd0);
    p0 = n_put;
    do_flush("midrst_empty_flush_done");
    chk("midrst_buffer_cleared", 64'(n_put - p0), 64'd0);

    // Random token stream, decoded back from the collected words.
    words.delete();
    bits = 0;
    for (int i = 0; i < 10000; i++) begin
      tw[i] = 4'($urandom_range(1, 13));
      v     = 13'($urandom);
      td[i] = v & 13'((1 << tw[i]) - 1);
      bits += int'(tw[i]);
      send(v, tw[i]);
    end
    do_flush("rand_flush_done");
    chk("rand_word_count", 64'(words.size()), 64'((bits + 63) / 64));
    bad = 0;
    pos = 0;
    if (words.size() == (bits + 63) / 64) begin
      for (int i = 0; i < 10000; i++) begin
        v = '0;
        for (int b = 0; b < int'(tw[i]); b++) begin
          last = words[pos / 64];
          v = {v[11:0], last[63 - (pos % 64)]};
          pos++;
        end
        if (v != td[i]) bad++;
      end
      pad_bad = 0;
      last = words[$];
      for (int p = pos; p < words.size() * 64; p++) begin
        if (last[63 - (p % 64)] !== 1'b0) pad_bad++;
      end
      chk("rand_pad_zero", 64'(pad_bad), 64'd0);
    end else begin
      bad = 10000;
    end
    chk("rand_token_errors", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
